shift_sequencer: RTL

// Multi-cycle barrel-shift controller for the ALU shift path. It applies a

---
 rtl/shift_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: one single-bit shift/rotate step per clock, amt times,
// behind a valid/ready request interface and a valid/ready result interface.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // Single-bit neighbour wiring for each of the four step kinds.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
    if (gi == 0) begin : g_lsb
      assign shl_v[gi] = 1'b0;
      assign rol_v[gi] = data_q[WIDTH-1];
    end else begin : g_lsb_n
      assign shl_v[gi] = data_q[gi-1];
      assign rol_v[gi] = data_q[gi-1];
    end
    if (gi == WIDTH-1) begin : g_msb
      assign shr_v[gi] = 1'b0;
      assign ror_v[gi] = data_q[0];
    end else begin : g_msb_n
      assign shr_v[gi] = data_q[gi+1];
      assign ror_v[gi] = data_q[gi+1];
    end
  end

  always_comb begin
    step_data  = shl_v;
    step_carry = data_q[WIDTH-1];
    case (mode_q)
      2'b00: begin step_data = shl_v; step_carry = data_q[WIDTH-1]; end
      2'b01: begin step_data = shr_v; step_carry = data_q[0];       end
      2'b10: begin step_data = rol_v; step_carry = data_q[WIDTH-1]; end
      default: begin step_data = ror_v; step_carry = data_q[0];     end
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    count_d = count_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          data_d  = op_a;
          mode_d  = mode;
          count_d = amt;
          carry_d = 1'b0;
          state_d = (amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d  = step_data;
        carry_d = step_carry;
        count_d = count_q - AMT_W'(1);
        // Last step lands in DONE on the same edge.
        if (count_q == AMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign result      = data_q;
  assign carry       = carry_q;

endmodule
